// File: rtl/adc_frame_packer.sv
// Captures a per-channel ADC sample vector on strobe and serializes it as a framed
// 32-bit AXI4-Stream: one tagged header word, then one sign-extended word per channel.
module adc_frame_packer #(
    parameter int unsigned ADC_CHANNELS   = 8,
    parameter int unsigned ADC_DATA_WIDTH = 18,
    parameter logic [7:0]  FRAME_MAGIC    = 8'hA5
) (
    input  logic                                   adc_read_clk,
    input  logic                                   rstn,
    input  logic                                   acq_en,
    input  logic                                   sample_valid,
    input  logic [ADC_DATA_WIDTH*ADC_CHANNELS-1:0] adc_data_arr,
    input  logic                                   overrun_clr,
    output logic [31:0]                            m_axis_tdata,
    output logic                                   m_axis_tvalid,
    input  logic                                   m_axis_tready,
    output logic                                   m_axis_tlast,
    output logic [31:0]                            sample_cnt,
    output logic                                   overrun,
    output logic                                   busy
);

    localparam int unsigned IDX_W = (ADC_CHANNELS > 1) ? $clog2(ADC_CHANNELS) : 1;
    localparam int unsigned EXT_W = 32 - ADC_DATA_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ADC_CHANNELS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StHdr,
        StChan
    } state_e;

    state_e                                 state;
    logic [IDX_W-1:0]                       idx;
    logic [ADC_DATA_WIDTH*ADC_CHANNELS-1:0] cap_data;
    logic [23:0]                            hdr_cnt;
    logic                                   acq_en_q;

    logic                      strobe;
    logic                      acq_rise;
    logic                      handshake;
    logic                      last_hs;
    logic                      slot_free;
    logic                      accept;
    logic                      drop;
    logic [31:0]               cnt_base;
    logic [ADC_DATA_WIDTH-1:0] chan_sample;

    assign strobe    = acq_en & sample_valid;
    assign acq_rise  = acq_en & ~acq_en_q;
    assign handshake = m_axis_tvalid & m_axis_tready;
    assign last_hs   = handshake & (state == StChan) & (idx == LAST_IDX);
    // The final beat leaving frees the slot in the same cycle, allowing gapless frames.
    assign slot_free = (state == StIdle) | last_hs;
    assign accept    = strobe & slot_free;
    assign drop      = strobe & ~slot_free;
    // A strobe coincident with the enable rise counts as sample 0.
    assign cnt_base  = acq_rise ? 32'd0 : sample_cnt;

    always_ff @(posedge adc_read_clk or negedge rstn) begin
        if (!rstn) begin
            state         <= StIdle;
            idx           <= '0;
            cap_data      <= '0;
            hdr_cnt       <= '0;
            acq_en_q      <= 1'b0;
            sample_cnt    <= '0;
            overrun       <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            busy          <= 1'b0;
        end else begin
            acq_en_q <= acq_en;

            if (strobe) begin
                sample_cnt <= cnt_base + 32'd1;
            end else if (acq_rise) begin
                sample_cnt <= '0;
            end

            if (drop) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end

            if (accept) begin
                cap_data <= adc_data_arr;
                hdr_cnt  <= cnt_base[23:0];
            end

            case (state)
                StIdle: begin
                    if (accept) begin
                        state         <= StHdr;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= 1'b0;
                        busy          <= 1'b1;
                    end
                end
                StHdr: begin
                    if (handshake) begin
                        state        <= StChan;
                        idx          <= '0;
                        m_axis_tlast <= (LAST_IDX == '0);
                    end
                end
                StChan: begin
                    if (handshake) begin
                        if (idx == LAST_IDX) begin
                            idx          <= '0;
                            m_axis_tlast <= 1'b0;
                            if (accept) begin
                                state <= StHdr;
                            end else begin
                                state         <= StIdle;
                                m_axis_tvalid <= 1'b0;
                                busy          <= 1'b0;
                            end
                        end else begin
                            idx          <= idx + IDX_W'(1);
                            m_axis_tlast <= ((idx + IDX_W'(1)) == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state         <= StIdle;
                    m_axis_tvalid <= 1'b0;
                    m_axis_tlast  <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

    // Data is a pure mux of held registers, so it stays stable while a beat is stalled.
    always_comb begin
        chan_sample  = cap_data[idx*ADC_DATA_WIDTH +: ADC_DATA_WIDTH];
        m_axis_tdata = '0;
        case (state)
            StHdr:   m_axis_tdata = {FRAME_MAGIC, hdr_cnt};
            StChan:  m_axis_tdata = {{EXT_W{chan_sample[ADC_DATA_WIDTH-1]}}, chan_sample};
            default: m_axis_tdata = '0;
        endcase
    end

endmodule
